// File: rtl/ram_dma_controller_if.sv
// rtl/ram_dma_controller_if.sv - burst bus signal bundle for ram_dma_controller
// Purpose: groups the shared-bus side of the DMA controller.
//   master modport: DMA controller (drives request, header, write data, end).
//   slave modport : bus/arbiter side (drives grant, read data, stall, error).
// Signals:
//   busRequest / busGrant                      bus ownership handshake
//   busAddress, busBurstSize, busReadNotWrite  burst header (size = words - 1)
//   busDataIn, busDataValidIn                  read-burst data
//   busDataOut, busDataValidOut, busBusy       write-burst data with stall
//   busEndTransaction, busError                burst termination
interface ram_dma_controller_if;
  logic        busRequest;
  logic        busGrant;
  logic [31:0] busAddress;
  logic [7:0]  busBurstSize;
  logic        busReadNotWrite;
  logic [31:0] busDataIn;
  logic        busDataValidIn;
  logic [31:0] busDataOut;
  logic        busDataValidOut;
  logic        busBusy;
  logic        busEndTransaction;
  logic        busError;

  modport master (
    output busRequest, busAddress, busBurstSize, busReadNotWrite,
           busDataOut, busDataValidOut, busEndTransaction,
    input  busGrant, busDataIn, busDataValidIn, busBusy, busError
  );

  modport slave (
    input  busRequest, busAddress, busBurstSize, busReadNotWrite,
           busDataOut, busDataValidOut, busEndTransaction,
    output busGrant, busDataIn, busDataValidIn, busBusy, busError
  );
endinterface

// File: rtl/ram_dma_controller.sv
// rtl/ram_dma_controller.sv - block DMA between a burst bus and an SSRAM port
// Purpose: moves blockSize words between bus memory and a local SSRAM in
//   bursts of at most burstSize+1 words, configured via custom instructions.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   ciStart/ciValueA/B       register access strobe, select [12:10], write [9]
//   ciDone/ciResult          one-cycle completion pulse with read data
//   bus (master modport)     burst bus, see ram_dma_controller_if
//   memAddress..memReadData  SSRAM port B, one cycle read latency
// Registers: 1 busStartAddress, 2 memStartAddress, 3 blockSize, 4 burstSize,
//   5 control (wr bit0 bus->SSRAM, bit1 SSRAM->bus) / status (bit0 busy,
//   bit1 error), 6 busy-cycle counter when DMA_PERF_COUNTER_EN is defined.
module ram_dma_controller #(
  parameter int nrOfEntries = 512,
  localparam int AW = $clog2(nrOfEntries)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ciStart,
  input  logic [31:0]         ciValueA,
  input  logic [31:0]         ciValueB,
  output logic                ciDone,
  output logic [31:0]         ciResult,
  ram_dma_controller_if.master bus,
  output logic [AW-1:0]       memAddress,
  output logic                memWriteEnable,
  output logic [31:0]         memWriteData,
  input  logic [31:0]         memReadData
);

  typedef enum logic [2:0] {
    IDLE, REQUEST, READ_BURST, PREFETCH, WRITE_BURST, END_BURST
  } state_t;

  state_t        state;
  logic [31:0]   busStartAddress;
  logic [AW-1:0] memStartAddress;
  logic [9:0]    blockSize;
  logic [7:0]    burstSize;
  logic          busy, error, toMemory;
  logic [31:0]   workBusAddress;
  logic [AW-1:0] workMemAddress;
  logic [9:0]    remaining;
  logic [8:0]    burstLength, beatCount;
  logic [31:0]   readValue;
`ifdef DMA_PERF_COUNTER_EN
  logic [31:0]   busyCycles;
`endif

  logic [2:0] regSelect;
  logic       regWrite, startReq, beatAccepted;
  logic [31:0] nextBusAddress;
  logic [9:0]  nextRemaining;
  logic        unusedCiBits;

  assign regSelect    = ciValueA[12:10];
  assign regWrite     = ciStart & ciValueA[9];
  assign startReq     = regWrite && (regSelect == 3'd5) && !busy && (ciValueB[1:0] != 2'b00);
  assign beatAccepted = ((state == READ_BURST) && bus.busDataValidIn) ||
                        ((state == WRITE_BURST) && !bus.busBusy);
  assign nextBusAddress = workBusAddress + {21'd0, burstLength, 2'b00};
  assign nextRemaining  = remaining - {1'b0, burstLength};
  assign unusedCiBits   = ^{ciValueA[31:13], ciValueA[8:0]};

  // Burst length in words: min(maxBurst + 1, words); never exceeds 256.
  function automatic logic [8:0] nextLength(input logic [9:0] words, input logic [7:0] maxBurst);
    logic [9:0] limit;
    limit = {2'b00, maxBurst} + 10'd1;
    return (words < limit) ? words[8:0] : limit[8:0];
  endfunction

  // Same length expressed as the bus header field (words - 1).
  function automatic logic [7:0] burstField(input logic [9:0] words, input logic [7:0] maxBurst);
    logic [9:0] wordsMinusOne;
    wordsMinusOne = words - 10'd1;
    return (words > {2'b00, maxBurst}) ? maxBurst : wordsMinusOne[7:0];
  endfunction

  function automatic logic [AW-1:0] nextMem(input logic [AW-1:0] a);
    return (a == AW'(nrOfEntries - 1)) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    readValue = '0;
    case (regSelect)
      3'd1: readValue = busStartAddress;
      3'd2: readValue = 32'(memStartAddress);
      3'd3: readValue = {22'd0, blockSize};
      3'd4: readValue = {24'd0, burstSize};
      3'd5: readValue = {30'd0, error, busy};
`ifdef DMA_PERF_COUNTER_EN
      3'd6: readValue = busyCycles;
`endif
      default: readValue = '0;
    endcase
  end

  // Read bursts stream straight into SSRAM; a word arriving with busError is dropped.
  assign memWriteEnable = (state == READ_BURST) && bus.busDataValidIn && !bus.busError;
  assign memWriteData   = memWriteEnable ? bus.busDataIn : '0;

  // workMemAddress is the word currently on busDataOut. When the bus accepts it
  // the next address is presented so its data lands one cycle later; when
  // stalled the same address is re-read, which holds busDataOut steady.
  assign bus.busDataValidOut = (state == WRITE_BURST);
  assign bus.busDataOut      = (state == WRITE_BURST) ? memReadData : '0;
  assign memAddress          = ((state == WRITE_BURST) && !bus.busBusy) ?
                               nextMem(workMemAddress) : workMemAddress;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      busStartAddress       <= '0;
      memStartAddress       <= '0;
      blockSize             <= '0;
      burstSize             <= '0;
      busy                  <= 1'b0;
      error                 <= 1'b0;
      toMemory              <= 1'b0;
      workBusAddress        <= '0;
      workMemAddress        <= '0;
      remaining             <= '0;
      burstLength           <= '0;
      beatCount             <= '0;
      ciDone                <= 1'b0;
      ciResult              <= '0;
      bus.busRequest        <= 1'b0;
      bus.busAddress        <= '0;
      bus.busBurstSize      <= '0;
      bus.busReadNotWrite   <= 1'b0;
      bus.busEndTransaction <= 1'b0;
`ifdef DMA_PERF_COUNTER_EN
      busyCycles            <= '0;
`endif
    end else begin
      ciDone   <= ciStart;
      ciResult <= ciStart ? readValue : '0;

      if (regWrite && !busy) begin
        case (regSelect)
          3'd1: busStartAddress <= ciValueB;
          3'd2: memStartAddress <= ciValueB[AW-1:0];
          3'd3: blockSize       <= ciValueB[9:0];
          3'd4: burstSize       <= ciValueB[7:0];
          default: ;
        endcase
      end

`ifdef DMA_PERF_COUNTER_EN
      if (startReq)
        busyCycles <= '0;
      else if (busy && (busyCycles != '1))
        busyCycles <= busyCycles + 32'd1;
`endif

      if ((state != IDLE) && bus.busError) begin
        state                 <= IDLE;
        busy                  <= 1'b0;
        error                 <= 1'b1;
        bus.busRequest        <= 1'b0;
        bus.busAddress        <= '0;
        bus.busBurstSize      <= '0;
        bus.busReadNotWrite   <= 1'b0;
        bus.busEndTransaction <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (startReq) begin
              error <= 1'b0;
              // An empty block completes on the spot without touching the bus.
              if (blockSize != 10'd0) begin
                state               <= REQUEST;
                busy                <= 1'b1;
                toMemory            <= ciValueB[0];
                workBusAddress      <= busStartAddress;
                workMemAddress      <= memStartAddress;
                remaining           <= blockSize;
                burstLength         <= nextLength(blockSize, burstSize);
                bus.busRequest      <= 1'b1;
                bus.busAddress      <= busStartAddress;
                bus.busBurstSize    <= burstField(blockSize, burstSize);
                bus.busReadNotWrite <= ciValueB[0];
              end
            end
          end
          REQUEST: begin
            if (bus.busGrant) begin
              bus.busRequest      <= 1'b0;
              bus.busAddress      <= '0;
              bus.busBurstSize    <= '0;
              bus.busReadNotWrite <= 1'b0;
              beatCount           <= '0;
              state               <= toMemory ? READ_BURST : PREFETCH;
            end
          end
          PREFETCH: state <= WRITE_BURST;
          READ_BURST, WRITE_BURST: begin
            if (beatAccepted) begin
              workMemAddress <= nextMem(workMemAddress);
              beatCount      <= beatCount + 9'd1;
              if (beatCount == burstLength - 9'd1) begin
                state                 <= END_BURST;
                bus.busEndTransaction <= 1'b1;
              end
            end
          end
          END_BURST: begin
            bus.busEndTransaction <= 1'b0;
            workBusAddress        <= nextBusAddress;
            remaining             <= nextRemaining;
            if (nextRemaining == 10'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state               <= REQUEST;
              burstLength         <= nextLength(nextRemaining, burstSize);
              bus.busRequest      <= 1'b1;
              bus.busAddress      <= nextBusAddress;
              bus.busBurstSize    <= burstField(nextRemaining, burstSize);
              bus.busReadNotWrite <= toMemory;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dma_controller.sv
// tb/tb_ram_dma_controller.sv - randomized self-checking bench for ram_dma_controller
module tb_ram_dma_controller;
  localparam int ENTRIES = 512;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart;
  logic [31:0] ciValueA, ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  logic [8:0]  memAddress;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  ram_dma_controller_if dma_bus();

  ram_dma_controller #(.nrOfEntries(ENTRIES)) dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciDone(ciDone), .ciResult(ciResult),
    .bus(dma_bus),
    .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  // SSRAM port B model: synchronous write, registered read.
  logic [31:0] ssram [ENTRIES];
  always @(posedge clock) begin
    if (memWriteEnable) ssram[memAddress] <= memWriteData;
    memReadData <= ssram[memAddress];
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [ENTRIES];
  logic [31:0] salt;
  logic [31:0] out_words [$];
  int          beat_index;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic ci_op(input logic [2:0] sel, input logic wr, input logic [31:0] data,
                       output logic [31:0] result);
    @(negedge clock);
    ciStart = 1'b1; ciValueA = {19'd0, sel, wr, 9'd0}; ciValueB = data;
    @(negedge clock);
    ciStart = 1'b0; ciValueA = '0; ciValueB = '0;
    check_eq("ci_done", 32'(ciDone), 32'd1);
    result = ciResult;
  endtask

  task automatic ci_write(input logic [2:0] sel, input logic [31:0] data);
    logic [31:0] r;
    ci_op(sel, 1'b1, data, r);
  endtask

  task automatic ci_read(input logic [2:0] sel, output logic [31:0] v);
    ci_op(sel, 1'b0, 32'd0, v);
  endtask

  task automatic serve_burst(input logic [31:0] exp_addr, input int exp_len, input logic rnw,
                             input int busy_pct, input int stall_after);
    int wait_n, got, forced;
    logic stall, prev_stall;
    logic [31:0] prev_data;
    wait_n = 0;
    while (dma_bus.busRequest !== 1'b1 && wait_n < 100) begin @(negedge clock); wait_n++; end
    check_eq("req_seen", 32'(dma_bus.busRequest), 32'd1);
    check_eq("hdr_addr", dma_bus.busAddress, exp_addr);
    check_eq("hdr_size", 32'(dma_bus.busBurstSize), 32'(exp_len - 1));
    check_eq("hdr_rnw", 32'(dma_bus.busReadNotWrite), 32'(rnw));
    repeat ($urandom_range(0, 2)) @(negedge clock);
    dma_bus.busGrant = 1'b1;
    @(negedge clock);
    dma_bus.busGrant = 1'b0;
    got = 0; wait_n = 0;
    if (rnw) begin
      while (got < exp_len && wait_n < 1000) begin
        if (int'($urandom_range(0, 99)) < busy_pct) dma_bus.busDataValidIn = 1'b0;
        else begin
          dma_bus.busDataValidIn = 1'b1;
          dma_bus.busDataIn = bus_word(exp_addr + 32'(4 * got));
          got++;
        end
        @(negedge clock); wait_n++;
      end
      dma_bus.busDataValidIn = 1'b0;
    end else begin
      @(negedge clock);
      forced = 0; prev_stall = 1'b0; prev_data = '0;
      while (got < exp_len && wait_n < 1000) begin
        if (beat_index == stall_after && forced < 2) begin stall = 1'b1; forced++; end
        else stall = (int'($urandom_range(0, 99)) < busy_pct);
        dma_bus.busBusy = stall;
        #1;
        check_eq("wr_valid", 32'(dma_bus.busDataValidOut), 32'd1);
        if (prev_stall) check_eq("wr_hold", dma_bus.busDataOut, prev_data);
        if (!stall) begin out_words.push_back(dma_bus.busDataOut); got++; beat_index++; end
        prev_stall = stall; prev_data = dma_bus.busDataOut;
        @(negedge clock); wait_n++;
      end
      dma_bus.busBusy = 1'b0;
    end
    wait_n = 0;
    while (dma_bus.busEndTransaction !== 1'b1 && wait_n < 20) begin @(negedge clock); wait_n++; end
    check_eq("end_pulse", 32'(dma_bus.busEndTransaction), 32'd1);
    @(negedge clock);
    check_eq("end_single", 32'(dma_bus.busEndTransaction), 32'd0);
  endtask

  task automatic run_transfer(input int ms, input logic [31:0] bsaddr, input int blk, input int burst,
                              input logic [1:0] ctrl, input int busy_pct, input int stall_after,
                              input logic poke);
    int rem, len, idx;
    logic [31:0] a, v;
    logic rnw;
    salt = $urandom;
    ci_write(3'd1, bsaddr);
    ci_write(3'd2, 32'(ms));
    ci_write(3'd3, 32'(blk));
    ci_write(3'd4, 32'(burst));
    ci_write(3'd5, {30'd0, ctrl});
    if (poke) begin
      ci_write(3'd3, 32'd77);
      ci_write(3'd5, 32'd3);
      ci_read(3'd5, v);
      check_eq("status_busy", v, 32'd1);
    end
    rnw = ctrl[0];
    out_words.delete(); beat_index = 0;
    rem = blk; a = bsaddr;
    while (rem > 0) begin
      len = (burst + 1 < rem) ? burst + 1 : rem;
      serve_burst(a, len, rnw, busy_pct, stall_after);
      a += 32'(4 * len); rem -= len;
    end
    ci_read(3'd5, v);
    check_eq("status_idle", v, 32'd0);
    ci_read(3'd1, v);
    check_eq("cfg_bus_addr", v, bsaddr);
    ci_read(3'd3, v);
    check_eq("cfg_block", v, 32'(blk));
    if (rnw) begin
      for (int i = 0; i < blk; i++) begin
        idx = (ms + i) % ENTRIES;
        ref_mem[idx] = bus_word(bsaddr + 32'(4 * i));
        check_eq("ssram_word", ssram[idx], ref_mem[idx]);
      end
    end else begin
      check_eq("wr_count", 32'(out_words.size()), 32'(blk));
      for (int i = 0; i < blk; i++)
        check_eq("wr_word", out_words[i], ref_mem[(ms + i) % ENTRIES]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int cnt, ms;
    reset = 1'b1; ciStart = 1'b0; ciValueA = '0; ciValueB = '0;
    dma_bus.busGrant = 1'b0; dma_bus.busDataIn = '0; dma_bus.busDataValidIn = 1'b0;
    dma_bus.busBusy = 1'b0; dma_bus.busError = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_req", 32'(dma_bus.busRequest), 32'd0);
    check_eq("rst_done", 32'(ciDone), 32'd0);
    check_eq("rst_result", ciResult, 32'd0);
    check_eq("rst_mem_we", 32'(memWriteEnable), 32'd0);
    reset = 1'b0;
    ci_read(3'd5, v);
    check_eq("rst_status", v, 32'd0);
    @(negedge clock);
    check_eq("done_single", 32'(ciDone), 32'd0);
    check_eq("result_idle", ciResult, 32'd0);

    // fill the whole SSRAM so later reads have known contents
    run_transfer(0, 32'h0000_8000, 512, 255, 2'b01, 20, -1, 1'b0);
    run_transfer(32'h010, 32'h0000_1000, 8, 3, 2'b01, 30, -1, 1'b0);
    run_transfer(32'h1FE, 32'h0000_4000, 4, 1, 2'b01, 0, -1, 1'b0);
    run_transfer(int'($urandom_range(0, 511)), 32'h0000_5000, 5, 7, 2'b10, 0, 2, 1'b0);
    run_transfer(32'h100, 32'h0000_6000, 6, 1, 2'b10, 20, -1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      run_transfer(int'($urandom_range(0, 511)), $urandom & 32'hFFFF_FFFC,
                   int'($urandom_range(1, 40)), int'($urandom_range(0, 15)),
                   2'($urandom_range(1, 3)), 30, -1, 1'b0);
    end

    ci_read(3'd6, v);
`ifdef DMA_PERF_COUNTER_EN
    check_eq("perf_nonzero", 32'(v != 0), 32'd1);
`else
    check_eq("perf_absent", v, 32'd0);
`endif
    ci_read(3'd7, v);
    check_eq("reg7_zero", v, 32'd0);
    ci_read(3'd0, v);
    check_eq("reg0_zero", v, 32'd0);

    // bus error on the second read word
    salt = $urandom;
    ci_write(3'd1, 32'h0000_2000);
    ci_write(3'd2, 32'h040);
    ci_write(3'd3, 32'd8);
    ci_write(3'd4, 32'd3);
    ci_write(3'd5, 32'd1);
    check_eq("err_req", 32'(dma_bus.busRequest), 32'd1);
    dma_bus.busGrant = 1'b1;
    @(negedge clock);
    dma_bus.busGrant = 1'b0;
    dma_bus.busDataValidIn = 1'b1; dma_bus.busDataIn = bus_word(32'h2000);
    @(negedge clock);
    dma_bus.busDataIn = bus_word(32'h2004); dma_bus.busError = 1'b1;
    @(negedge clock);
    dma_bus.busError = 1'b0; dma_bus.busDataValidIn = 1'b0;
    #1;
    check_eq("err_req_drop", 32'(dma_bus.busRequest), 32'd0);
    check_eq("err_end_drop", 32'(dma_bus.busEndTransaction), 32'd0);
    check_eq("err_mem_we", 32'(memWriteEnable), 32'd0);
    ref_mem[32'h040] = bus_word(32'h2000);
    check_eq("err_first_word", ssram[32'h040], ref_mem[32'h040]);
    ci_read(3'd5, v);
    check_eq("err_status", v, 32'd2);

    // empty block: start clears error, never requests the bus
    ci_write(3'd3, 32'd0);
    ci_write(3'd5, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dma_bus.busRequest === 1'b1) cnt++;
    end
    check_eq("zero_blk_req", 32'(cnt), 32'd0);
    ci_read(3'd5, v);
    check_eq("zero_blk_status", v, 32'd0);

    // reset in the middle of a write burst
    ms = int'($urandom_range(0, 511));
    ci_write(3'd1, 32'h0000_3000);
    ci_write(3'd2, 32'(ms));
    ci_write(3'd3, 32'd6);
    ci_write(3'd4, 32'd7);
    ci_write(3'd5, 32'd2);
    dma_bus.busGrant = 1'b1;
    @(negedge clock);
    dma_bus.busGrant = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("pre_rst_valid", 32'(dma_bus.busDataValidOut), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(dma_bus.busDataValidOut), 32'd0);
    check_eq("mid_rst_data", dma_bus.busDataOut, 32'd0);
    check_eq("mid_rst_req", 32'(dma_bus.busRequest), 32'd0);
    check_eq("mid_rst_addr", dma_bus.busAddress, 32'd0);
    check_eq("mid_rst_mem_addr", 32'(memAddress), 32'd0);
    check_eq("mid_rst_end", 32'(dma_bus.busEndTransaction), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ci_read(3'd5, v);
    check_eq("post_rst_status", v, 32'd0);
    ci_read(3'd3, v);
    check_eq("post_rst_block", v, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
